// File: rtl/dffers_ctrl_seq.sv
// Control sequencer for a bank of dffers flops. It turns CLEAR/PRESET/LOAD/NOP commands
// into timed, registered D/E/Rn/Sn waveforms, and adds a recovery gap after every async pulse.
module dffers_ctrl_seq #(
    parameter int WIDTH     = 8,
    parameter int PULSE_LEN = 2,
    parameter int RECOV     = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] ff_D,
    output logic             ff_E,
    output logic [WIDTH-1:0] ff_Rn,
    output logic [WIDTH-1:0] ff_Sn,
    output logic             busy,
    output logic             done
);

    localparam int MAXC = (PULSE_LEN > RECOV) ? PULSE_LEN : RECOV;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PULSE_C = CW'(PULSE_LEN);
    localparam logic [CW-1:0] RECOV_C = CW'(RECOV);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_PULSE = 3'd1,
        ST_GAP   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_IDLE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    // Set when the current GAP follows a command pulse, so its exit reports done.
    logic              pend, pend_nxt;
    logic [WIDTH-1:0]  d_nxt, rn_nxt, sn_nxt;
    logic              e_nxt, ready_nxt, done_nxt;

    always_ff @(posedge clk) begin
        if (R) begin
            state     <= ST_RST;
            cnt       <= '0;
            pend      <= 1'b0;
            ff_D      <= '0;
            ff_E      <= 1'b0;
            ff_Rn     <= '0;
            ff_Sn     <= '1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend      <= pend_nxt;
            ff_D      <= d_nxt;
            ff_E      <= e_nxt;
            ff_Rn     <= rn_nxt;
            ff_Sn     <= sn_nxt;
            cmd_ready <= ready_nxt;
            busy      <= ~ready_nxt;
            done      <= done_nxt;
        end
    end

    // Next state and next registered output values; every output leaves a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        d_nxt     = ff_D;
        e_nxt     = 1'b0;
        rn_nxt    = '1;
        sn_nxt    = '1;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            ST_RST: begin
                state_nxt = ST_GAP;
                cnt_nxt   = RECOV_C;
                pend_nxt  = 1'b0;
            end

            ST_PULSE: begin
                if (cnt == ONE_C) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = RECOV_C;
                    pend_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - ONE_C;
                    rn_nxt  = ff_Rn;
                    sn_nxt  = ff_Sn;
                end
            end

            ST_GAP: begin
                if (cnt == ONE_C) begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                    done_nxt  = pend;
                    pend_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt - ONE_C;
                end
            end

            ST_LOAD: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
                done_nxt  = 1'b1;
            end

            ST_IDLE: begin
                ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        OP_NOP: begin
                            done_nxt = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_nxt = ST_PULSE;
                            cnt_nxt   = PULSE_C;
                            rn_nxt    = ~cmd_data;
                            ready_nxt = 1'b0;
                        end
                        OP_PRESET: begin
                            state_nxt = ST_PULSE;
                            cnt_nxt   = PULSE_C;
                            sn_nxt    = ~cmd_data;
                            ready_nxt = 1'b0;
                        end
                        OP_LOAD: begin
                            state_nxt = ST_LOAD;
                            d_nxt     = cmd_data;
                            e_nxt     = 1'b1;
                            ready_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

endmodule

// File: doc/dffers_ctrl_seq.md
Name: dffers_ctrl_seq

Overview:
- Control sequencer directly upstream of a WIDTH-bit bank of dffers flops (enable, active-low async reset, active-low async set).
- Accepts CLEAR / PRESET / LOAD / NOP commands over a valid/ready interface.
- Drives the bank's D, E, R and S pins with timed pulses and enforces a recovery gap after async set/reset release before the next command.
- All outputs are registered, so the bank sees glitch-free control lines.

Parameters:
- WIDTH, 8: number of downstream flops (bits of D/R/S buses).
- PULSE_LEN, 2: cycles an async reset/set line is held low; must be >= 1.
- RECOV, 2: cycles all lines are held inactive after a pulse ends or after reset; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- R  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  00 NOP, 01 CLEAR, 10 PRESET, 11 LOAD.
- cmd_data  in  WIDTH  bit mask for CLEAR/PRESET; data for LOAD.
- ff_D  out  WIDTH  D bus to the flops.
- ff_E  out  1  enable to the flops.
- ff_Rn  out  WIDTH  per-bit active-low reset to the flops.
- ff_Sn  out  WIDTH  per-bit active-low set to the flops.
- busy  out  1  equals the inverse of cmd_ready.
- done  out  1  one-cycle pulse on the first IDLE cycle after a command completes.

Behaviour:
- States: RST, PULSE, GAP, LOAD, IDLE.
- Acceptance: a command is accepted in cycle t when cmd_valid & cmd_ready. cmd_op and cmd_data are captured at that edge. Inputs are ignored when cmd_ready is 0.
- While R=1, regardless of state:
  - State is RST.
  - ff_Rn = all 0 (whole bank held cleared), ff_Sn = all 1, ff_E = 0, ff_D = 0.
  - cmd_ready = 0, done = 0.
- First cycle with R=0 after reset: enter GAP for RECOV cycles with ff_Rn = all 1, then IDLE. No done pulse on this path. cmd_ready first goes high RECOV+1 cycles after R falls.
- R asserted mid-command aborts immediately, with no done pulse; the captured command is discarded.
- Inactive levels in IDLE and GAP: ff_Rn = all 1, ff_Sn = all 1, ff_E = 0, ff_D holds its last value.
- CLEAR accepted at t:
  - Cycles t+1 .. t+PULSE_LEN: ff_Rn = ~mask; ff_Sn = all 1.
  - Then GAP for RECOV cycles.
  - IDLE with done=1 at cycle t+PULSE_LEN+RECOV+1.
- PRESET: identical timing to CLEAR, with ff_Sn = ~mask and ff_Rn = all 1.
- The block never drives the same bit low on ff_Rn and ff_Sn in the same cycle.
- LOAD accepted at t:
  - Cycle t+1: ff_E = 1, ff_D = data.
  - Cycle t+2: IDLE, ff_E = 0, done = 1.
  - ff_D retains data afterwards.
- NOP accepted at t: cycle t+1 is IDLE with done=1; outputs unchanged.
- Back-to-back commands: a new command may be accepted in the same cycle done=1, because cmd_ready is high there.
- An all-zero mask on CLEAR/PRESET still runs the full PULSE+GAP timing; no output bit toggles.
- Counters are sized to hold max(PULSE_LEN, RECOV); they load at state entry and count down to 1.

Test Plan (WIDTH=8, PULSE_LEN=2, RECOV=2):
- R high for 3 cycles, then low -> ff_Rn=0x00 during reset; ff_Rn=0xFF and cmd_ready=0 for 2 cycles after release; cmd_ready=1 on the 3rd cycle; done never pulses.
- CLEAR mask 0x0F accepted at t -> ff_Rn=0xF0 at t+1 and t+2; 0xFF at t+3 and t+4; done=1 and cmd_ready=1 at t+5; ff_Sn=0xFF throughout.
- PRESET mask 0x81, then LOAD 0x5A issued back-to-back while cmd_valid stays high -> ff_Sn=0x7E for 2 cycles; 2 gap cycles; LOAD accepted in PRESET's done cycle; one cycle later ff_E=1 with ff_D=0x5A; done the next cycle.
- R asserted in the 1st PULSE cycle of CLEAR 0xFF -> next cycle ff_Rn=0x00, state RST; no done; command not resumed after release.
- cmd_valid held high while busy with changing cmd_data -> only the value present at acceptance is used; other values are ignored.
- NOP, then CLEAR with mask 0x00 -> NOP gives done at t+1; CLEAR gives done at t+5 with ff_Rn constant at 0xFF.
